// File: rtl/jtframe_serjoy_pkg.sv
// Shared types, mode encodings and helpers for the serial joystick reader.
package jtframe_serjoy_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        CMP,
        GAP
    } state_t;

    localparam logic [1:0] MODE_OFF = 2'd0;
    localparam logic [1:0] MODE_1P  = 2'd1;
    localparam logic [1:0] MODE_2P  = 2'd2;

    // Requested player count limited to what the chain was built for
    function automatic logic [2:0] clamp_players(input logic [1:0] mode,
                                                 input int unsigned max_players);
        logic [2:0] m;
        m = {1'b0, mode};
        if (32'(m) > max_players) begin
            m = 3'(max_players);
        end
        return m;
    endfunction

endpackage

// File: rtl/jtframe_serjoy_tick.sv
// Free-running prescaler: one-cycle tick every DIV system clocks.
module jtframe_serjoy_tick #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0] pre_reg;

    assign tick = (pre_reg == PW'(DIV - 1));

    // Count 0..DIV-1 and wrap; only the reset restarts the phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_reg <= '0;
        end else if (tick) begin
            pre_reg <= '0;
        end else begin
            pre_reg <= pre_reg + PW'(1);
        end
    end

endmodule

// File: rtl/jtframe_serjoy.sv
// Serial (DB15/SNAC) joystick chain reader with a two-scan agreement
// filter and runtime player count.
module jtframe_serjoy
    import jtframe_serjoy_pkg::*;
#(
    parameter int PLAYERS    = 2,
    parameter int BITS       = 12,
    parameter int DIV        = 4,
    parameter int LOAD_TICKS = 2,
    parameter int GAP_TICKS  = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              mode,
    input  logic                    joy_data,
    output logic                    joy_clk,
    output logic                    joy_load,
    output logic                    active,
    output logic [PLAYERS*BITS-1:0] joy_out,
    output logic                    upd,
    output logic                    scan_err
);
    localparam int PB = PLAYERS * BITS;
    localparam int CW = $clog2(PB + 1);
    localparam int LW = $clog2(LOAD_TICKS + 1);
    localparam int GW = $clog2(GAP_TICKS + 1);

    logic          tick;
    state_t        state_reg;
    logic [2:0]    n_reg;
    logic [2:0]    n_req;
    logic [CW-1:0] total_reg;
    logic [CW-1:0] cnt_reg;
    logic [LW-1:0] lcnt_reg;
    logic [GW-1:0] gcnt_reg;
    logic          phase_reg;
    logic [PB-1:0] raw_reg;
    logic [PB-1:0] prev_reg;
    logic          prev_vld_reg;
    logic [PB-1:0] out_reg;
    logic [PB-1:0] pmask;
    logic          data_s1_reg;
    logic          data_s2_reg;
    logic          joy_clk_reg;
    logic          joy_load_reg;
    logic          active_reg;
    logic          upd_reg;
    logic          err_reg;

    jtframe_serjoy_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign n_req = clamp_players(mode, PLAYERS);

    // Players beyond the latched chain length never reach joy_out
    for (genvar gi = 0; gi < PLAYERS; gi++) begin : g_mask
        assign pmask[gi*BITS +: BITS] = (32'(n_reg) > gi) ? {BITS{1'b1}} : {BITS{1'b0}};
    end

    // Two-flop synchroniser on the serial line; idles released (high)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_s1_reg <= 1'b1;
            data_s2_reg <= 1'b1;
        end else begin
            data_s1_reg <= joy_data;
            data_s2_reg <= data_s1_reg;
        end
    end

    // User-port mode select follows the requested mode one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_reg <= 1'b0;
        end else begin
            active_reg <= (mode != MODE_OFF);
        end
    end

    // Scan sequencer: load strobe, bit shifting, agreement filter, idle gap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            n_reg        <= '0;
            total_reg    <= '0;
            cnt_reg      <= '0;
            lcnt_reg     <= '0;
            gcnt_reg     <= '0;
            phase_reg    <= 1'b0;
            raw_reg      <= '0;
            prev_reg     <= '0;
            prev_vld_reg <= 1'b0;
            out_reg      <= '0;
            joy_clk_reg  <= 1'b0;
            joy_load_reg <= 1'b0;
            upd_reg      <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            upd_reg <= 1'b0;
            err_reg <= 1'b0;
            if (state_reg != IDLE && tick && mode == MODE_OFF) begin
                // Turning the port off abandons the scan and forgets history
                state_reg    <= IDLE;
                joy_clk_reg  <= 1'b0;
                joy_load_reg <= 1'b0;
                out_reg      <= '0;
                prev_reg     <= '0;
                prev_vld_reg <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        joy_clk_reg  <= 1'b0;
                        joy_load_reg <= 1'b0;
                        if (mode == MODE_OFF) begin
                            out_reg      <= '0;
                            prev_vld_reg <= 1'b0;
                        end else if (tick) begin
                            n_reg     <= n_req;
                            total_reg <= CW'(32'(n_req) * BITS);
                            if (n_req != n_reg) begin
                                // A different chain length makes the old scan meaningless
                                prev_reg     <= '0;
                                prev_vld_reg <= 1'b0;
                            end
                            raw_reg   <= '0;
                            lcnt_reg  <= '0;
                            state_reg <= LOAD;
                        end
                    end
                    LOAD: begin
                        if (tick) begin
                            if (lcnt_reg == LW'(LOAD_TICKS)) begin
                                joy_load_reg <= 1'b0;
                                cnt_reg      <= '0;
                                phase_reg    <= 1'b0;
                                state_reg    <= SHIFT;
                            end else begin
                                joy_load_reg <= 1'b1;
                                lcnt_reg     <= lcnt_reg + LW'(1);
                            end
                        end
                    end
                    SHIFT: begin
                        if (tick) begin
                            if (!phase_reg) begin
                                // First bit out lands at the top of the active window
                                raw_reg     <= {raw_reg[PB-2:0], ~data_s2_reg};
                                joy_clk_reg <= 1'b1;
                                phase_reg   <= 1'b1;
                            end else begin
                                joy_clk_reg <= 1'b0;
                                phase_reg   <= 1'b0;
                                cnt_reg     <= cnt_reg + CW'(1);
                                if (cnt_reg == total_reg - CW'(1)) begin
                                    state_reg <= CMP;
                                end
                            end
                        end
                    end
                    CMP: begin
                        if (prev_vld_reg && raw_reg == prev_reg) begin
                            out_reg <= raw_reg & pmask;
                            upd_reg <= 1'b1;
                        end else if (prev_vld_reg) begin
                            err_reg <= 1'b1;
                        end
                        prev_reg     <= raw_reg;
                        prev_vld_reg <= 1'b1;
                        gcnt_reg     <= '0;
                        state_reg    <= GAP;
                    end
                    GAP: begin
                        if (tick) begin
                            if (gcnt_reg == GW'(GAP_TICKS - 1)) begin
                                state_reg <= IDLE;
                            end else begin
                                gcnt_reg <= gcnt_reg + GW'(1);
                            end
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign joy_clk  = joy_clk_reg;
    assign joy_load = joy_load_reg;
    assign active   = active_reg;
    assign joy_out  = out_reg;
    assign upd      = upd_reg;
    assign scan_err = err_reg;

endmodule

// File: tb/tb_jtframe_serjoy.sv
// Bench for jtframe_serjoy: adapter model, per-scan scoreboard, reset and
// abort sequences.
`timescale 1ns/1ps
module tb_jtframe_serjoy;
    import jtframe_serjoy_pkg::*;

    localparam int PLAYERS    = 2;
    localparam int BITS       = 12;
    localparam int DIV        = 4;
    localparam int LOAD_TICKS = 2;
    localparam int GAP_TICKS  = 4;
    localparam int NROWS      = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode = MODE_2P;
    logic        joy_data;
    logic        joy_clk;
    logic        joy_load;
    logic        active;
    logic [23:0] joy_out;
    logic        upd;
    logic        scan_err;

    always #5 clk = ~clk;

    jtframe_serjoy #(
        .PLAYERS    (PLAYERS),
        .BITS       (BITS),
        .DIV        (DIV),
        .LOAD_TICKS (LOAD_TICKS),
        .GAP_TICKS  (GAP_TICKS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .joy_data (joy_data),
        .joy_clk  (joy_clk),
        .joy_load (joy_load),
        .active   (active),
        .joy_out  (joy_out),
        .upd      (upd),
        .scan_err (scan_err)
    );

    // Adapter model: parallel load while joy_load is high, shift on joy_clk rise.
    // Wire levels are active-low; the first bit out is the top of the chain word.
    logic [11:0] m_p1 = 12'h000;
    logic [11:0] m_p2 = 12'h000;
    logic [23:0] m_sr = 24'hFFFFFF;
    logic        m_prev_clk = 1'b0;
    assign joy_data = m_sr[23];

    always @(posedge clk) begin
        if (joy_load) begin
            m_sr <= (mode == MODE_1P) ? {~m_p1, 12'hFFF} : {~m_p2, ~m_p1};
        end else if (joy_clk && !m_prev_clk) begin
            m_sr <= {m_sr[22:0], 1'b1};
        end
        m_prev_clk <= joy_clk;
    end

    typedef struct {
        logic [1:0]  mode;
        logic [11:0] p1;
        logic [11:0] p2;
        logic        exp_upd;
        logic        exp_err;
        logic [23:0] exp_out;
        int          exp_edges;
    } vec_t;

    typedef struct {
        logic        upd;
        logic        err;
        logic [23:0] out;
        int          edges;
        int          tag;
    } exp_t;

    vec_t tbl [0:NROWS-1];
    exp_t exp_q [$];
    int   checks = 0;
    int   errors = 0;

    // Monitor state
    int   rises = 0;
    int   gap = 0;
    logic spacing_bad = 1'b0;
    logic pending = 1'b0;
    logic mon_clk = 1'b0;
    logic mon_load = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: the outcome of a scan shows up one cycle after the last joy_clk fall
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                gap++;
                if (pending) begin
                    e = exp_q.pop_front();
                    $display("row %0d: upd=%0b scan_err=%0b joy_out=%06h", e.tag, upd, scan_err, joy_out);
                    check("upd", {31'd0, upd}, {31'd0, e.upd});
                    check("scan_err", {31'd0, scan_err}, {31'd0, e.err});
                    check("joy_out", {8'd0, joy_out}, {8'd0, e.out});
                    check("clk_spacing", {31'd0, spacing_bad}, 32'd0);
                    pending = 1'b0;
                end else if (upd || scan_err) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: upd=%0b scan_err=%0b, expected neither", upd, scan_err);
                end
                if (joy_load && !mon_load) begin
                    rises = 0;
                    spacing_bad = 1'b0;
                end
                if (joy_clk && !mon_clk) begin
                    if (rises > 0 && gap != 2*DIV) spacing_bad = 1'b1;
                    rises++;
                    gap = 0;
                end
                if (!joy_clk && mon_clk && exp_q.size() > 0 && rises == exp_q[0].edges) begin
                    pending = 1'b1;
                end
                mon_clk  = joy_clk;
                mon_load = joy_load;
            end
        end
    end

    task automatic push_row(input int i);
        exp_t e;
        mode = tbl[i].mode;
        m_p1 = tbl[i].p1;
        m_p2 = tbl[i].p2;
        e.upd   = tbl[i].exp_upd;
        e.err   = tbl[i].exp_err;
        e.out   = tbl[i].exp_out;
        e.edges = tbl[i].exp_edges;
        e.tag   = i;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input int i);
        int t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scan_timeout row %0d: got no outcome in %0d cycles, expected one", i, t);
            exp_q.delete();
        end
    endtask

    initial begin
        int cyc;
        int hi;
        tbl[0] = '{MODE_2P, 12'h801, 12'h0F0, 1'b0, 1'b0, 24'h000000, 24};
        tbl[1] = '{MODE_2P, 12'h801, 12'h0F0, 1'b1, 1'b0, 24'h0F0801, 24};
        tbl[2] = '{MODE_2P, 12'h001, 12'h0F0, 1'b0, 1'b1, 24'h0F0801, 24};
        tbl[3] = '{MODE_2P, 12'h002, 12'h0F0, 1'b0, 1'b1, 24'h0F0801, 24};
        tbl[4] = '{MODE_2P, 12'h001, 12'h0F0, 1'b0, 1'b1, 24'h0F0801, 24};
        tbl[5] = '{MODE_2P, 12'h001, 12'h0F0, 1'b1, 1'b0, 24'h0F0001, 24};
        tbl[6] = '{MODE_1P, 12'h801, 12'h0F0, 1'b0, 1'b0, 24'h0F0001, 12};
        tbl[7] = '{MODE_1P, 12'h801, 12'h0F0, 1'b1, 1'b0, 24'h000801, 12};
        tbl[8] = '{2'd3,    12'h801, 12'h0F0, 1'b0, 1'b0, 24'h000801, 24};
        tbl[9] = '{2'd3,    12'h801, 12'h0F0, 1'b1, 1'b0, 24'h0F0801, 24};

        // Reset with the port enabled and the line idle
        rst_n = 1'b0;
        push_row(0);
        repeat (3) @(negedge clk);
        check("rst_joy_clk",  {31'd0, joy_clk},  32'd0);
        check("rst_joy_load", {31'd0, joy_load}, 32'd0);
        check("rst_active",   {31'd0, active},   32'd0);
        check("rst_joy_out",  {8'd0, joy_out},   32'd0);
        check("rst_upd",      {31'd0, upd},      32'd0);
        check("rst_scan_err", {31'd0, scan_err}, 32'd0);

        // First load strobe rises at the second tick and lasts LOAD_TICKS ticks
        rst_n = 1'b1;
        cyc = 0;
        while (!joy_load && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("load_rise_cycles", cyc, 2*DIV);
        check("active_on", {31'd0, active}, 32'd1);
        hi = 0;
        while (joy_load && hi < 50) begin
            @(negedge clk);
            hi++;
        end
        check("load_high_cycles", hi, LOAD_TICKS*DIV);
        wait_drain(0);

        // One scan per table row; inputs change only during the gap
        for (int i = 1; i < NROWS; i++) begin
            @(negedge clk);
            push_row(i);
            wait_drain(i);
        end

        // Switch the port off in the middle of a scan
        @(negedge clk);
        mode = MODE_2P;
        m_p1 = 12'h123;
        m_p2 = 12'h456;
        cyc = 0;
        while (!joy_load && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        while (rises != 10 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_reached_bit10", rises, 10);
        mode = MODE_OFF;
        @(negedge clk);
        check("abort_active", {31'd0, active}, 32'd0);
        repeat (DIV - 1) @(negedge clk);
        check("abort_joy_clk",  {31'd0, joy_clk},  32'd0);
        check("abort_joy_load", {31'd0, joy_load}, 32'd0);
        check("abort_joy_out",  {8'd0, joy_out},   32'd0);
        repeat (40) @(negedge clk);
        check("off_joy_out",  {8'd0, joy_out},   32'd0);
        check("off_joy_load", {31'd0, joy_load}, 32'd0);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
